// File: rtl/fifo_sync_arb_ctrl.sv
// Write-side round-robin arbiter, read-side drain into a registered tx stream,
// and occupancy tracking for one shared fifo_sync instance.
module fifo_sync_arb_ctrl #(
   parameter int PTR_WIDTH  = 4,
   parameter int FIFO_DEPTH = 16,
   parameter int FIFO_WIDTH = 32,
   parameter int BURST_LEN  = 4,
   parameter int AF_THRESH  = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   input  logic [FIFO_WIDTH-1:0] req0_data,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [FIFO_WIDTH-1:0] req1_data,
   output logic                  req1_ready,
   output logic                  fifo_write,
   output logic [FIFO_WIDTH-1:0] fifo_in,
   input  logic                  fifo_full,
   output logic                  fifo_read,
   input  logic [FIFO_WIDTH-1:0] fifo_out,
   input  logic                  fifo_empty,
   output logic                  tx_valid,
   output logic [FIFO_WIDTH-1:0] tx_data,
   input  logic                  tx_ready,
   output logic [PTR_WIDTH:0]    level,
   output logic                  almost_full
);

   localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BCW-1:0]     BURST_LAST = BCW'(BURST_LEN - 1);
   localparam logic [PTR_WIDTH:0] AF_LVL     = (PTR_WIDTH+1)'(AF_THRESH);
   localparam logic [PTR_WIDTH:0] DEPTH_LVL  = (PTR_WIDTH+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_t;

   arb_state_t            state_r, state_s;
   logic                  last_gnt_r, last_gnt_s;
   logic [BCW-1:0]        burst_cnt_r, burst_cnt_s;
   logic [PTR_WIDTH:0]    level_r, level_s;
   logic                  almost_full_r;
   logic                  tx_valid_r;
   logic [FIFO_WIDTH-1:0] tx_data_r;
   logic                  pop_s;

   // A granted writer is accepted whenever the FIFO has room; full stalls in place.
   assign req0_ready = (state_r == GNT0) & req0_valid & ~fifo_full;
   assign req1_ready = (state_r == GNT1) & req1_valid & ~fifo_full;
   assign fifo_write = req0_ready | req1_ready;
   assign fifo_in    = (state_r == GNT1) ? req1_data :
                       (state_r == GNT0) ? req0_data : {FIFO_WIDTH{1'b0}};

   // The tx register refills from the show-ahead FIFO whenever it is empty or being consumed.
   assign pop_s     = ~fifo_empty & (~tx_valid_r | tx_ready);
   assign fifo_read = pop_s;

   assign tx_valid    = tx_valid_r;
   assign tx_data     = tx_data_r;
   assign level       = level_r;
   assign almost_full = almost_full_r;

   // Arbiter next state, burst counting and round-robin pointer.
   always_comb begin
      state_s     = state_r;
      last_gnt_s  = last_gnt_r;
      burst_cnt_s = burst_cnt_r;
      case (state_r)
         IDLE: begin
            if (last_gnt_r) begin
               if (req0_valid)      state_s = GNT0;
               else if (req1_valid) state_s = GNT1;
               else                 state_s = IDLE;
            end else begin
               if (req1_valid)      state_s = GNT1;
               else if (req0_valid) state_s = GNT0;
               else                 state_s = IDLE;
            end
         end
         GNT0: begin
            if (!req0_valid || (req0_ready && burst_cnt_r == BURST_LAST)) begin
               last_gnt_s  = 1'b0;
               burst_cnt_s = {BCW{1'b0}};
               if (req1_valid)      state_s = GNT1;
               else if (req0_valid) state_s = GNT0;
               else                 state_s = IDLE;
            end else if (req0_ready) begin
               burst_cnt_s = burst_cnt_r + 1'b1;
            end else begin
               burst_cnt_s = burst_cnt_r;
            end
         end
         GNT1: begin
            if (!req1_valid || (req1_ready && burst_cnt_r == BURST_LAST)) begin
               last_gnt_s  = 1'b1;
               burst_cnt_s = {BCW{1'b0}};
               if (req0_valid)      state_s = GNT0;
               else if (req1_valid) state_s = GNT1;
               else                 state_s = IDLE;
            end else if (req1_ready) begin
               burst_cnt_s = burst_cnt_r + 1'b1;
            end else begin
               burst_cnt_s = burst_cnt_r;
            end
         end
         default: begin
            state_s     = IDLE;
            last_gnt_s  = 1'b1;
            burst_cnt_s = {BCW{1'b0}};
         end
      endcase
   end

   // Occupancy follows the controller's own write/pop strobes; saturation is purely defensive.
   always_comb begin
      case ({fifo_write, pop_s})
         2'b10:   level_s = (level_r == DEPTH_LVL) ? level_r : level_r + 1'b1;
         2'b01:   level_s = (level_r == {(PTR_WIDTH+1){1'b0}}) ? level_r : level_r - 1'b1;
         default: level_s = level_r;
      endcase
   end

   // State, tx stream and occupancy registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= IDLE;
         last_gnt_r    <= 1'b1;
         burst_cnt_r   <= {BCW{1'b0}};
         level_r       <= {(PTR_WIDTH+1){1'b0}};
         almost_full_r <= 1'b0;
         tx_valid_r    <= 1'b0;
         tx_data_r     <= {FIFO_WIDTH{1'b0}};
      end else begin
         state_r       <= state_s;
         last_gnt_r    <= last_gnt_s;
         burst_cnt_r   <= burst_cnt_s;
         level_r       <= level_s;
         almost_full_r <= (level_s >= AF_LVL);
         if (pop_s) begin
            tx_valid_r <= 1'b1;
            tx_data_r  <= fifo_out;
         end else if (tx_ready) begin
            tx_valid_r <= 1'b0;
         end else begin
            tx_valid_r <= tx_valid_r;
         end
      end
   end

endmodule

// File: tb/tb_fifo_sync_arb_ctrl.sv
// Directed bench for fifo_sync_arb_ctrl with a behavioural 16-entry show-ahead
// fifo_sync attached; each task drives one scenario and checks inline.
module tb_fifo_sync_arb_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [31:0] req0_data, req1_data;
   logic        fifo_write, fifo_full, fifo_read, fifo_empty;
   logic [31:0] fifo_in, fifo_out;
   logic        tx_valid, tx_ready;
   logic [31:0] tx_data;
   logic [4:0]  level;
   logic        almost_full;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [31:0] src0[$];
   logic [31:0] src1[$];
   logic [31:0] wlog[$];
   logic [31:0] txq[$];
   int          acc_cyc[$];

   fifo_sync_arb_ctrl dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .fifo_write(fifo_write), .fifo_in(fifo_in), .fifo_full(fifo_full),
      .fifo_read(fifo_read), .fifo_out(fifo_out), .fifo_empty(fifo_empty),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .level(level), .almost_full(almost_full)
   );

   always #5 clk = ~clk;

   // Attached fifo_sync: 16 entries, show-ahead output.
   logic [31:0] mem [16];
   logic [3:0]  wp, rp;
   logic [4:0]  cnt;
   assign fifo_full  = (cnt == 5'd16);
   assign fifo_empty = (cnt == 5'd0);
   assign fifo_out   = mem[rp];
   always @(posedge clk) begin
      if (rst) begin
         wp <= 4'd0; rp <= 4'd0; cnt <= 5'd0;
      end else begin
         if (fifo_write && !fifo_full) begin
            mem[wp] <= fifo_in;
            wp <= wp + 4'd1;
         end
         if (fifo_read && !fifo_empty) rp <= rp + 4'd1;
         cnt <= cnt + {4'd0, fifo_write && !fifo_full} - {4'd0, fifo_read && !fifo_empty};
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, cyc=%0d required finish", cyc);
      $fatal(1, "watchdog");
   end

   task automatic apply();
      req0_valid = (src0.size() != 0);
      req0_data  = (src0.size() != 0) ? src0[0] : 32'h0;
      req1_valid = (src1.size() != 0);
      req1_data  = (src1.size() != 0) ? src1[0] : 32'h0;
   endtask

   // Record handshakes just before the edge, then advance to the next negedge.
   task automatic cycle();
      #1;
      checks++;
      if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
         errors++;
         $display("FAIL both_ready cyc=%0d: got both high, required at most one", cyc);
      end
      if (req0_ready === 1'b1) begin
         wlog.push_back(req0_data); void'(src0.pop_front()); acc_cyc.push_back(cyc);
      end
      if (req1_ready === 1'b1) begin
         wlog.push_back(req1_data); void'(src1.pop_front()); acc_cyc.push_back(cyc);
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) txq.push_back(tx_data);
      @(posedge clk);
      @(negedge clk);
      apply();
      cyc++;
   endtask

   task automatic clear_logs();
      wlog.delete(); txq.delete(); acc_cyc.delete();
   endtask

   task automatic test_reset();
      src0.delete(); src1.delete(); clear_logs();
      tx_ready = 1'b0;
      rst = 1'b1;
      apply();
      cycle(); cycle();
      rst = 1'b0;
      #1;
      checks++;
      if ({tx_valid, almost_full, level} !== 7'd0 || tx_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_regs: got tx_valid=%b af=%b level=%0d tx_data=%h, required 0", tx_valid, almost_full, level, tx_data);
      end
      checks++;
      if ({req0_ready, req1_ready, fifo_write, fifo_read} !== 4'b0000 || fifo_in !== 32'h0) begin
         errors++;
         $display("FAIL reset_comb: got r0=%b r1=%b wr=%b rd=%b in=%h, required 0", req0_ready, req1_ready, fifo_write, fifo_read, fifo_in);
      end
   endtask

   task automatic test_single_writer();
      int first = -1;
      int peak  = 0;
      clear_logs();
      tx_ready = 1'b1;
      src0.push_back(32'hA000_000A); src0.push_back(32'hB000_000B); src0.push_back(32'hC000_000C);
      apply();
      for (int k = 0; k < 12; k++) begin
         if (tx_valid === 1'b1 && first < 0) first = k;
         if (int'(level) > peak) peak = int'(level);
         cycle();
      end
      checks++;
      if (first != 3) begin
         errors++;
         $display("FAIL single_latency: got first tx_valid at %0d clk, required 3", first);
      end
      checks++;
      if (peak > 2) begin
         errors++;
         $display("FAIL single_peak: got level peak %0d, required <= 2", peak);
      end
      checks++;
      if (level !== 5'd0) begin
         errors++;
         $display("FAIL single_level_end: got %0d, required 0", level);
      end
      checks++;
      if (txq.size() != 3 || txq[0] !== 32'hA000_000A || txq[1] !== 32'hB000_000B || txq[2] !== 32'hC000_000C) begin
         errors++;
         $display("FAIL single_order: got %0d beats first=%h, required A,B,C", txq.size(), (txq.size() > 0) ? txq[0] : 32'h0);
      end
   endtask

   task automatic test_round_robin();
      logic [31:0] exp;
      int n = 0;
      int bad = 0;
      test_reset();
      tx_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         src0.push_back(32'h100 + i);
         src1.push_back(32'h200 + i);
      end
      apply();
      while ((wlog.size() < 24 || txq.size() < 24) && n < 100) begin
         cycle();
         n++;
      end
      checks++;
      if (n >= 100) begin
         errors++;
         $display("FAIL rr_timeout: got %0d writes %0d tx, required 24", wlog.size(), txq.size());
      end
      for (int g = 0; g < 6; g++) begin
         for (int b = 0; b < 4; b++) begin
            exp = ((g % 2) != 0 ? 32'h200 : 32'h100) + (g / 2) * 4 + b;
            checks++;
            if (wlog.size() <= g*4+b || wlog[g*4+b] !== exp || txq.size() <= g*4+b || txq[g*4+b] !== exp) begin
               bad++;
               errors++;
               $display("FAIL rr_order idx=%0d: got wr=%h tx=%h, required %h", g*4+b,
                        (wlog.size() > g*4+b) ? wlog[g*4+b] : 32'hx, (txq.size() > g*4+b) ? txq[g*4+b] : 32'hx, exp);
            end
         end
      end
      checks++;
      if (acc_cyc.size() != 24 || acc_cyc[23] - acc_cyc[0] != 23) begin
         errors++;
         $display("FAIL rr_no_gap: got %0d accepts spanning %0d clk, required 24 spanning 23", acc_cyc.size(),
                  (acc_cyc.size() > 0) ? acc_cyc[acc_cyc.size()-1] - acc_cyc[0] : -1);
      end
   endtask

   task automatic test_fill_stall();
      test_reset();
      tx_ready = 1'b0;
      for (int i = 0; i < 18; i++) src0.push_back(32'h300 + i);
      apply();
      for (int k = 0; k < 30; k++) begin
         checks++;
         if (almost_full !== (level >= 5'd12)) begin
            errors++;
            $display("FAIL fill_af level=%0d: got af=%b, required %b", level, almost_full, level >= 5'd12);
         end
         cycle();
      end
      #1;
      checks++;
      if (level !== 5'd16 || almost_full !== 1'b1) begin
         errors++;
         $display("FAIL fill_level: got level=%0d af=%b, required 16 and 1", level, almost_full);
      end
      checks++;
      if (req0_valid !== 1'b1 || req0_ready !== 1'b0 || src0.size() != 1 || wlog.size() != 17) begin
         errors++;
         $display("FAIL fill_stall: got ready=%b pending=%0d accepted=%0d, required 0,1,17", req0_ready, src0.size(), wlog.size());
      end
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 32'h300) begin
         errors++;
         $display("FAIL fill_txreg: got valid=%b data=%h, required 1 and 00000300", tx_valid, tx_data);
      end
   endtask

   task automatic test_full_concurrent();
      logic       w, r;
      logic [4:0] lv;
      for (int i = 18; i < 24; i++) src0.push_back(32'h300 + i);
      tx_ready = 1'b1;
      apply();
      for (int k = 0; k < 24; k++) begin
         #1;
         w = fifo_write; r = fifo_read; lv = level;
         cycle();
         checks++;
         if (level !== lv + {4'd0, w} - {4'd0, r} || level !== cnt) begin
            errors++;
            $display("FAIL conc_level k=%0d: got %0d (fifo holds %0d), required %0d", k, level, cnt, lv + {4'd0, w} - {4'd0, r});
         end
      end
      checks++;
      if (txq.size() != 24) begin
         errors++;
         $display("FAIL conc_contig: got %0d beats in 24 clk, required 24", txq.size());
      end
      for (int i = 0; i < 24; i++) begin
         checks++;
         if (txq.size() <= i || txq[i] !== 32'h300 + i) begin
            errors++;
            $display("FAIL conc_order idx=%0d: got %h, required %h", i, (txq.size() > i) ? txq[i] : 32'hx, 32'h300 + i);
         end
      end
      for (int k = 0; k < 3; k++) cycle();
      checks++;
      if (level !== 5'd0 || tx_valid !== 1'b0) begin
         errors++;
         $display("FAIL conc_drained: got level=%0d valid=%b, required 0 and 0", level, tx_valid);
      end
   endtask

   task automatic test_ready_toggle();
      logic        stall;
      logic [31:0] held;
      test_reset();
      for (int i = 0; i < 6; i++) src0.push_back(32'h500 + i);
      apply();
      for (int k = 0; k < 40; k++) begin
         tx_ready = k[0];
         #1;
         stall = (tx_valid === 1'b1 && tx_ready === 1'b0);
         held  = tx_data;
         if (stall) begin
            checks++;
            if (fifo_read !== 1'b0) begin
               errors++;
               $display("FAIL toggle_nopop k=%0d: got fifo_read=%b, required 0", k, fifo_read);
            end
         end
         cycle();
         if (stall) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== held) begin
               errors++;
               $display("FAIL toggle_hold k=%0d: got valid=%b data=%h, required 1 and %h", k, tx_valid, tx_data, held);
            end
         end
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (txq.size() != 6 || txq[i] !== 32'h500 + i) begin
            errors++;
            $display("FAIL toggle_order idx=%0d: got %h (%0d beats), required %h", i, (txq.size() > i) ? txq[i] : 32'hx, txq.size(), 32'h500 + i);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      int n = 0;
      test_reset();
      tx_ready = 1'b0;
      for (int i = 0; i < 8; i++) src0.push_back(32'h600 + i);
      apply();
      while (level !== 5'd5 && n < 20) begin
         cycle();
         n++;
      end
      checks++;
      if (level !== 5'd5 || tx_valid !== 1'b1) begin
         errors++;
         $display("FAIL midrst_setup: got level=%0d valid=%b, required 5 and 1", level, tx_valid);
      end
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      src0.delete();
      apply();
      #1;
      checks++;
      if (level !== 5'd0 || tx_valid !== 1'b0 || tx_data !== 32'h0 || almost_full !== 1'b0) begin
         errors++;
         $display("FAIL midrst_regs: got level=%0d valid=%b data=%h, required 0", level, tx_valid, tx_data);
      end
      checks++;
      if (req0_ready !== 1'b0 || fifo_write !== 1'b0) begin
         errors++;
         $display("FAIL midrst_idle: got r0=%b wr=%b, required 0 (IDLE)", req0_ready, fifo_write);
      end
      clear_logs();
      tx_ready = 1'b1;
      src1.push_back(32'h0000_D00D);
      apply();
      n = 0;
      while (txq.size() == 0 && n < 20) begin
         cycle();
         n++;
      end
      checks++;
      if (txq.size() == 0 || txq[0] !== 32'h0000_D00D) begin
         errors++;
         $display("FAIL midrst_first: got %h, required 0000d00d", (txq.size() > 0) ? txq[0] : 32'hx);
      end
   endtask

   initial begin
      test_reset();
      test_single_writer();
      test_round_robin();
      test_fill_stall();
      test_full_concurrent();
      test_ready_toggle();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
